ex_mem_reg: RTL and testbench

Parametrised, clocked EX→MEM pipeline register that replaces the combinational EX/MEM pass-through stage.
- Carries the GPR write-back fields, the HI/LO write-back fields, and the multi-cycle multiply-accumulate state (cycle count, 2×DW partial product).
- Adds a per-stage stall vector, synchronous flush, bubble insertion and a valid bit.
- Sits between the ex and mem stages. Its mem_cnt / mem_hilo_tempt outputs also loop back to ex for madd/msub sequencing.

---
 rtl/cpu_pipe_pkg.sv | 40 ++++
 rtl/pipe_stage_ctl.sv | 27 ++
 rtl/ex_mem_reg.sv | 127 ++++++++++++
 tb/tb_ex_mem_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: default widths, stall-vector stage indices,
// write-back / multiply-accumulate bundles and stage control one-hot.
package cpu_pipe_pkg;

    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int CNT_W   = 5;
    localparam int STALL_W = 6;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef struct packed {
        logic          valid;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          whilo;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
    } wb_bundle_t;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [2*DW-1:0]  hilo_tempt;
    } mac_state_t;

    // Exactly one bit is set every cycle.
    typedef struct packed {
        logic load;
        logic bubble;
        logic hold;
        logic clear;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_stage_ctl.sv
// Decodes flush and the stall bits of this stage and the next one into
// one-hot load / bubble / hold / clear controls for a pipeline register.
//   flush      : synchronous flush, wins over any stall
//   stall_self : stall bit of the stage feeding this register
//   stall_next : stall bit of the stage consuming this register
//   ctl        : one-hot control bundle
module pipe_stage_ctl
    import cpu_pipe_pkg::*;
(
    input  logic       flush,
    input  logic       stall_self,
    input  logic       stall_next,
    output stage_ctl_t ctl
);

    always_comb begin
        ctl = '0;
        unique case (1'b1)
            flush:                                     ctl.clear  = 1'b1;
            (!flush &&  stall_self && !stall_next):    ctl.bubble = 1'b1;
            (!flush && !stall_self):                   ctl.load   = 1'b1;
            (!flush &&  stall_self &&  stall_next):    ctl.hold   = 1'b1;
            default:                                   ctl        = '0;
        endcase
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: write-back fields, HI/LO fields and the
// multi-cycle madd/msub state, with flush, bubble, hold and valid bit.
//   clk, reset_n      : clock, async active-low reset
//   stall, flush      : per-stage stall vector, synchronous flush
//   ex_*              : fields produced by EX this cycle
//   mem_*             : registered fields; mem_cnt/mem_hilo_tempt loop to EX
module ex_mem_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DW      = cpu_pipe_pkg::DW,
    parameter int AW      = cpu_pipe_pkg::AW,
    parameter int CNT_W   = cpu_pipe_pkg::CNT_W,
    parameter int STALL_W = cpu_pipe_pkg::STALL_W,
    parameter int EX_IDX  = STALL_EX,
    parameter int MEM_IDX = STALL_MEM
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic               ex_we,
    input  logic [AW-1:0]      ex_waddr,
    input  logic [DW-1:0]      ex_wdata,
    input  logic               ex_whilo,
    input  logic [DW-1:0]      ex_hi,
    input  logic [DW-1:0]      ex_lo,
    input  logic [CNT_W-1:0]   ex_cnt,
    input  logic [2*DW-1:0]    ex_hilo_tempt,
    output logic               mem_valid,
    output logic               mem_we,
    output logic [AW-1:0]      mem_waddr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_whilo,
    output logic [DW-1:0]      mem_hi,
    output logic [DW-1:0]      mem_lo,
    output logic [CNT_W-1:0]   mem_cnt,
    output logic [2*DW-1:0]    mem_hilo_tempt
);

    typedef struct packed {
        logic          valid;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          whilo;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
    } wb_t;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [2*DW-1:0]  hilo_tempt;
    } mac_t;

    stage_ctl_t ctl;
    wb_t        wb_d, wb_q;
    mac_t       mac_d, mac_q;

    // Only the EX and MEM bits matter here.
    logic unused_stall;
    assign unused_stall = ^stall;

    pipe_stage_ctl u_ctl (
        .flush      (flush),
        .stall_self (stall[EX_IDX]),
        .stall_next (stall[MEM_IDX]),
        .ctl        (ctl)
    );

    always_comb begin
        wb_d  = wb_q;
        mac_d = mac_q;
        unique case (1'b1)
            ctl.clear: begin
                wb_d  = '0;
                mac_d = '0;
            end
            // Bubble to MEM, but keep the madd/msub progress alive.
            ctl.bubble: begin
                wb_d            = '0;
                mac_d.cnt        = ex_cnt;
                mac_d.hilo_tempt = ex_hilo_tempt;
            end
            // A captured instruction ends any multi-cycle sequence.
            ctl.load: begin
                wb_d.valid = ex_valid;
                wb_d.we    = ex_valid & ex_we;
                wb_d.waddr = ex_waddr;
                wb_d.wdata = ex_wdata;
                wb_d.whilo = ex_valid & ex_whilo;
                wb_d.hi    = ex_hi;
                wb_d.lo    = ex_lo;
                mac_d      = '0;
            end
            ctl.hold: begin
                wb_d  = wb_q;
                mac_d = mac_q;
            end
            default: begin
                wb_d  = wb_q;
                mac_d = mac_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_q  <= '0;
            mac_q <= '0;
        end else begin
            wb_q  <= wb_d;
            mac_q <= mac_d;
        end
    end

    assign mem_valid      = wb_q.valid;
    assign mem_we         = wb_q.we;
    assign mem_waddr      = wb_q.waddr;
    assign mem_wdata      = wb_q.wdata;
    assign mem_whilo      = wb_q.whilo;
    assign mem_hi         = wb_q.hi;
    assign mem_lo         = wb_q.lo;
    assign mem_cnt        = mac_q.cnt;
    assign mem_hilo_tempt = mac_q.hilo_tempt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: directed vectors push expected
// outputs, a monitor pops and compares one cycle later.
module tb_ex_mem_reg;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [4:0]  cnt;
        logic [63:0] ht;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_valid, ex_we, ex_whilo;
    logic [4:0]  ex_waddr, ex_cnt;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic [63:0] ex_hilo_tempt;
    logic        mem_valid, mem_we, mem_whilo;
    logic [4:0]  mem_waddr, mem_cnt;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [63:0] mem_hilo_tempt;

    obs_t  exp_q[$];
    string nm_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_we          (ex_we),
        .ex_waddr       (ex_waddr),
        .ex_wdata       (ex_wdata),
        .ex_whilo       (ex_whilo),
        .ex_hi          (ex_hi),
        .ex_lo          (ex_lo),
        .ex_cnt         (ex_cnt),
        .ex_hilo_tempt  (ex_hilo_tempt),
        .mem_valid      (mem_valid),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .mem_whilo      (mem_whilo),
        .mem_hi         (mem_hi),
        .mem_lo         (mem_lo),
        .mem_cnt        (mem_cnt),
        .mem_hilo_tempt (mem_hilo_tempt)
    );

    function automatic obs_t mk(logic v, logic we, logic [4:0] wa,
                                logic [31:0] wd, logic wh,
                                logic [31:0] hi, logic [31:0] lo,
                                logic [4:0] cnt, logic [63:0] ht);
        obs_t o;
        o.valid = v;   o.we = we;   o.waddr = wa;
        o.wdata = wd;  o.whilo = wh;
        o.hi = hi;     o.lo = lo;
        o.cnt = cnt;   o.ht = ht;
        return o;
    endfunction

    function automatic obs_t cur();
        return {mem_valid, mem_we, mem_waddr, mem_wdata, mem_whilo,
                mem_hi, mem_lo, mem_cnt, mem_hilo_tempt};
    endfunction

    task automatic cmp(input string nm, input obs_t got, input obs_t want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic apply(input obs_t x);
        ex_valid = x.valid;  ex_we = x.we;  ex_waddr = x.waddr;
        ex_wdata = x.wdata;  ex_whilo = x.whilo;
        ex_hi = x.hi;        ex_lo = x.lo;
        ex_cnt = x.cnt;      ex_hilo_tempt = x.ht;
    endtask

    task automatic push(input obs_t e, input string nm);
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic step(input logic fl, input logic [5:0] st,
                        input obs_t in, input obs_t e, input string nm);
        @(negedge clk);
        flush = fl;
        stall = st;
        apply(in);
        push(e, nm);
    endtask

    // Monitor: the register presents a new value after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                obs_t  e;
                string n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                cmp(n, cur(), e);
            end
        end
    end

    // ctrl must never stall MEM while EX runs.
    always @(posedge clk) begin
        if (reset_n)
            assert (!(stall[4] && !stall[3]))
            else $error("illegal stall vector %b", stall);
    end

    localparam obs_t Z = '0;

    initial begin
        obs_t a, b, h1, h2;
        reset_n = 1'b0;
        flush   = 1'b0;
        stall   = 6'b0;
        a = mk(1, 1, 5'd3, 32'h1234_5678, 1, 32'hAAAA_0000,
               32'h0000_5555, 5'd3, 64'h11);
        apply(a);
        repeat (2) @(negedge clk);
        cmp("rst_init", cur(), Z);
        reset_n = 1'b1;
        push(mk(1, 1, 5'd3, 32'h1234_5678, 1, 32'hAAAA_0000,
                32'h0000_5555, 5'd0, 64'h0), "first_cap");

        b = mk(1, 1, 5'd7, 32'hDEAD_BEEF, 0, 32'h0, 32'h0, 5'd0, 64'h0);
        step(0, 6'b000000, b, b, "pass");

        step(0, 6'b000000,
             mk(1, 0, 5'h1F, 32'hFFFF_FFFF, 1, 32'h1234_5678,
                32'h9ABC_DEF0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF),
             mk(1, 0, 5'h1F, 32'hFFFF_FFFF, 1, 32'h1234_5678,
                32'h9ABC_DEF0, 5'd0, 64'h0), "pass_hilo");

        step(0, 6'b001111,
             mk(1, 1, 5'd9, 32'h55, 1, 32'h1, 32'h2, 5'd1,
                64'h0000_0001_0000_0002),
             mk(0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd1,
                64'h0000_0001_0000_0002), "madd_bubble");

        step(0, 6'b000000,
             mk(1, 1, 5'd9, 32'h55, 1, 32'h1, 32'h2, 5'd2,
                64'h0000_0001_0000_0002),
             mk(1, 1, 5'd9, 32'h55, 1, 32'h1, 32'h2, 5'd0, 64'h0),
             "madd_done");

        h1 = mk(1, 1, 5'h0A, 32'hCAFE_F00D, 1, 32'h0000_1111,
                32'h2222_0000, 5'd0, 64'h0);
        step(0, 6'b000000, h1, h1, "hold_load");
        step(0, 6'b011111,
             mk(0, 0, 5'h15, 32'h1, 0, 32'h3, 32'h4, 5'd9, 64'h77),
             h1, "hold_1");
        step(0, 6'b011111,
             mk(1, 1, 5'h01, 32'hFFFF_0000, 1, 32'h5, 32'h6, 5'd2, 64'h88),
             h1, "hold_2");
        step(0, 6'b111111,
             mk(0, 1, 5'h1E, 32'h0000_FFFF, 0, 32'h7, 32'h8, 5'd31, 64'h99),
             h1, "hold_3");

        h2 = mk(0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd1,
                64'h0000_0001_0000_0002);
        step(0, 6'b001111,
             mk(1, 1, 5'd4, 32'h44, 1, 32'h4, 32'h4, 5'd1,
                64'h0000_0001_0000_0002), h2, "bubble_pre_hold");
        step(0, 6'b011111,
             mk(1, 1, 5'd5, 32'h45, 1, 32'h5, 32'h5, 5'd6, 64'h66),
             h2, "hold_mac");

        step(1, 6'b011111,
             mk(1, 1, 5'd6, 32'h46, 1, 32'h6, 32'h6, 5'd2, 64'h67),
             Z, "flush_hold");
        step(1, 6'b000000,
             mk(1, 1, 5'd8, 32'h48, 1, 32'h8, 32'h8, 5'd3, 64'h68),
             Z, "flush_load");

        step(0, 6'b000000,
             mk(0, 1, 5'h0C, 32'h77, 1, 32'h88, 32'h99, 5'd4, 64'h5),
             mk(0, 0, 5'h0C, 32'h77, 0, 32'h88, 32'h99, 5'd0, 64'h0),
             "invalid");

        step(0, 6'b000111,
             mk(1, 1, 5'h12, 32'h1357_9BDF, 0, 32'hA, 32'hB, 5'd5, 64'h3),
             mk(1, 1, 5'h12, 32'h1357_9BDF, 0, 32'hA, 32'hB, 5'd0, 64'h0),
             "other_bits");

        step(0, 6'b001111,
             mk(1, 1, 5'h11, 32'h0BAD_C0DE, 1, 32'h1, 32'h2, 5'd4, 64'h5),
             mk(0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h0, 5'd4, 64'h5),
             "bubble_pre_rst");

        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        cmp("rst_async", cur(), Z);
        @(negedge clk);
        cmp("rst_held", cur(), Z);
        reset_n = 1'b1;
        stall = 6'b000000;
        apply(mk(1, 0, 5'h13, 32'h2468_ACE0, 1, 32'hC, 32'hD, 5'd1, 64'h9));
        push(mk(1, 0, 5'h13, 32'h2468_ACE0, 1, 32'hC, 32'hD, 5'd0, 64'h0),
             "post_rst_cap");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
